// File: rtl/pitch_resampler_if.sv
// pitch_resampler_if: tick/ratio, ring-buffer read handshake and output-sample bus of the resampler
interface pitch_resampler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int INT_BITS   = 2
);
  logic                           sample_tick_in;
  logic [INT_BITS+FRAC_BITS-1:0]  ratio_in;
  logic                           read_trigger_out;
  logic signed [DATA_WIDTH-1:0]   data_in;
  logic                           data_valid_in;
  logic signed [DATA_WIDTH-1:0]   sample_out;
  logic                           sample_valid_out;
  logic                           busy_out;
  logic                           overrun_out;
  modport master (
    output sample_tick_in, ratio_in, data_in, data_valid_in,
    input  read_trigger_out, sample_out, sample_valid_out, busy_out, overrun_out
  );
  modport slave (
    input  sample_tick_in, ratio_in, data_in, data_valid_in,
    output read_trigger_out, sample_out, sample_valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/pitch_resampler.sv
// pitch_resampler: steps through ring-buffer samples at a fractional pitch ratio and linearly interpolates one output per tick
module pitch_resampler #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int INT_BITS   = 2
) (
  input logic              clk_in,
  input logic              rst_in,
  pitch_resampler_if.slave bus
);
  localparam int AW = INT_BITS + FRAC_BITS + 1;
  localparam int NW = INT_BITS + 1;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + FRAC_BITS + 2;
  typedef enum logic [2:0] {IDLE, READ, WAIT, MUL, ADD} state_t;
  state_t                       state;
  logic [FRAC_BITS-1:0]         frac;
  logic [NW-1:0]                n_left;
  logic signed [DATA_WIDTH-1:0] s0, s1;
  logic signed [PW-1:0]         prod;
  logic [AW-1:0]                acc;
  always_comb acc = AW'(frac) + AW'(bus.ratio_in);
  // read_trigger_out is set on entry to READ so it is high for exactly the READ cycle
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state                <= IDLE;
      frac                 <= '0;
      n_left               <= '0;
      s0                   <= '0;
      s1                   <= '0;
      prod                 <= '0;
      bus.read_trigger_out <= 1'b0;
      bus.sample_out       <= '0;
      bus.sample_valid_out <= 1'b0;
      bus.busy_out         <= 1'b0;
      bus.overrun_out      <= 1'b0;
    end else begin
      bus.read_trigger_out <= 1'b0;
      bus.sample_valid_out <= 1'b0;
      if (bus.sample_tick_in && state != IDLE) bus.overrun_out <= 1'b1;
      case (state)
        IDLE: if (bus.sample_tick_in) begin
          {n_left, frac}       <= acc;
          state                <= acc[AW-1:FRAC_BITS] != '0 ? READ : MUL;
          bus.read_trigger_out <= acc[AW-1:FRAC_BITS] != '0;
          bus.busy_out         <= 1'b1;
        end
        READ: state <= WAIT;
        WAIT: if (bus.data_valid_in) begin
          s0                   <= s1;
          s1                   <= bus.data_in;
          n_left               <= n_left - NW'(1);
          state                <= n_left != NW'(1) ? READ : MUL;
          bus.read_trigger_out <= n_left != NW'(1);
        end
        MUL: begin
          prod  <= PW'(DW1'(s1) - DW1'(s0)) * PW'($signed({1'b0, frac}));
          state <= ADD;
        end
        ADD: begin
          bus.sample_out       <= s0 + DATA_WIDTH'(prod >>> FRAC_BITS);
          bus.sample_valid_out <= 1'b1;
          bus.busy_out         <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pitch_resampler.sv
// tb_pitch_resampler: directed vectors for ratio stepping, signed interpolation, overrun and async reset
module tb_pitch_resampler;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam int IB = 2;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;
  pitch_resampler_if #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .INT_BITS(IB)) bus ();
  pitch_resampler #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .INT_BITS(IB)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  logic signed [DW-1:0] feed [$];
  typedef struct {
    logic                 rst;
    logic [IB+FB-1:0]     ratio;
    int                   extra;
    int                   reads;
    logic signed [DW-1:0] d0, d1, d2;
    logic signed [DW-1:0] smp;
    int                   lat;
  } vec_t;
  vec_t tbl [14];
  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    bus.sample_tick_in = 1'b0;
    bus.data_valid_in = 1'b0;
    feed.delete();
    @(negedge clk_in);
    check("rst_sample", bus.sample_out, 0);
    check("rst_flags", {bus.read_trigger_out, bus.sample_valid_out, bus.busy_out, bus.overrun_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask
  task automatic tick(input logic [IB+FB-1:0] r, input int extra, output int lat, output int reads,
                      output logic signed [DW-1:0] smp, output int adj);
    int pend;
    logic prev;
    pend = -1;
    prev = 1'b0;
    lat = -1;
    reads = 0;
    adj = 0;
    smp = 'x;
    bus.sample_tick_in = 1'b1;
    bus.ratio_in = r;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk_in);
      bus.sample_tick_in = 1'b0;
      bus.data_valid_in = 1'b0;
      if (bus.read_trigger_out) begin
        reads++;
        if (prev) adj++;
        pend = k + 1 + extra;
      end
      prev = bus.read_trigger_out;
      if (k == pend && feed.size() > 0) begin
        bus.data_valid_in = 1'b1;
        bus.data_in = feed.pop_front();
      end
      if (bus.sample_valid_out) begin
        lat = k;
        smp = bus.sample_out;
      end
    end
  endtask
  initial begin
    int lat, reads, adj, nv, nt, ok, pend, bad;
    logic signed [DW-1:0] smp;
    bus.sample_tick_in = 1'b0;
    bus.ratio_in = '0;
    bus.data_in = '0;
    bus.data_valid_in = 1'b0;
    tbl[0]  = '{1'b1, 18'h10000, 0, 1, 100, 0, 0, 0, 5};
    tbl[1]  = '{1'b0, 18'h10000, 0, 1, 200, 0, 0, 100, 5};
    tbl[2]  = '{1'b0, 18'h10000, 0, 1, 300, 0, 0, 200, 5};
    tbl[3]  = '{1'b1, 18'h08000, 0, 0, 0, 0, 0, 0, 3};
    tbl[4]  = '{1'b0, 18'h08000, 0, 1, 100, 0, 0, 0, 5};
    tbl[5]  = '{1'b0, 18'h08000, 0, 0, 0, 0, 0, 50, 3};
    tbl[6]  = '{1'b0, 18'h08000, 0, 1, 200, 0, 0, 100, 5};
    tbl[7]  = '{1'b0, 18'h08000, 0, 0, 0, 0, 0, 150, 3};
    tbl[8]  = '{1'b1, 18'h20000, 0, 2, 1000, -1000, 0, 1000, 7};
    tbl[9]  = '{1'b0, 18'h04000, 0, 0, 0, 0, 0, 500, 3};
    tbl[10] = '{1'b0, 18'h24000, 0, 2, 0, -1, 0, -1, 7};
    tbl[11] = '{1'b0, 18'h10000, 2, 1, 7, 0, 0, 3, 7};
    tbl[12] = '{1'b1, 18'h3FFFF, 0, 3, 10, 20, 30, 29, 9};
    tbl[13] = '{1'b0, 18'h00000, 0, 0, 0, 0, 0, 29, 3};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].reads > 0) feed.push_back(tbl[i].d0);
      if (tbl[i].reads > 1) feed.push_back(tbl[i].d1);
      if (tbl[i].reads > 2) feed.push_back(tbl[i].d2);
      tick(tbl[i].ratio, tbl[i].extra, lat, reads, smp, adj);
      check($sformatf("v%0d_sample", i), smp, tbl[i].smp);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_reads", i), reads, tbl[i].reads);
      check($sformatf("v%0d_adjacent", i), adj, 0);
    end
    do_reset();
    nv = 0;
    nt = 0;
    ok = 0;
    pend = -1;
    for (int k = 0; k < 45; k++) begin
      if (bus.sample_valid_out) begin
        nv++;
        if (k % 9 == 7) ok++;
      end
      if (bus.read_trigger_out) begin
        nt++;
        pend = k + 1;
      end
      if (k == 2) check("ovr_before_drop", bus.overrun_out, 0);
      bus.sample_tick_in = (k % 3 == 0) && (k < 30);
      bus.ratio_in = 18'h20000;
      bus.data_valid_in = (k == pend);
      bus.data_in = k + 1;
      @(negedge clk_in);
    end
    bus.sample_tick_in = 1'b0;
    bus.data_valid_in = 1'b0;
    check("ovr_valids", nv, 4);
    check("ovr_valid_timing", ok, 4);
    check("ovr_triggers", nt, 8);
    check("ovr_sticky", bus.overrun_out, 1);
    check("pre_rst_sample_nonzero", bus.sample_out != 0, 1);
    bus.sample_tick_in = 1'b1;
    bus.ratio_in = 18'h10000;
    @(negedge clk_in);
    bus.sample_tick_in = 1'b0;
    @(negedge clk_in);
    check("wait_busy", bus.busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("async_rst_sample", bus.sample_out, 0);
    check("async_rst_flags", {bus.read_trigger_out, bus.sample_valid_out, bus.busy_out, bus.overrun_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.data_valid_in = 1'b1;
    bus.data_in = 555;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      bus.data_valid_in = 1'b0;
      if (bus.read_trigger_out || bus.sample_valid_out || bus.busy_out) bad++;
    end
    check("post_rst_quiet", bad, 0);
    tick(18'h00000, 0, lat, reads, smp, adj);
    check("post_rst_sample", smp, 0);
    check("post_rst_latency", lat, 3);
    check("post_rst_reads", reads, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
